rbm_sequencer: RTL

- On-chip controller that replaces the bench-side sequencing of the RBM datapath (Main).
- Each iteration it walks every hidden neuron over all visible pixels plus bias, then latches the hidden bit.
- It then walks every class neuron over all latched hidden bits plus bias and accumulates spike counts.
- It repeats for iter_num iterations, then reports the per-class spike counts.

---
 rtl/rbm_pkg.sv | 23 ++
 rtl/rbm_spike_counter_bank.sv | 76 +++++++
 rtl/rbm_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rbm_pkg.sv
// Shared defaults, index widths and FSM state type for the RBM sequencer.
// RBM_SEQ_ARGMAX_EN adds an argmax state ahead of StDone.
package rbm_pkg;

  localparam int unsigned N_VISIBLE_DEF = 784;
  localparam int unsigned N_HIDDEN_DEF  = 441;
  localparam int unsigned N_CLASS_DEF   = 10;

  localparam int unsigned PIX_W = 10;
  localparam int unsigned HID_W = 9;
  localparam int unsigned CLS_W = 4;

  // Cycles in one full hidden + classifier pass at the default sizes.
  localparam int unsigned ITER_CYCLES =
      N_HIDDEN_DEF * (N_VISIBLE_DEF + 2) + N_CLASS_DEF * (N_HIDDEN_DEF + 2);

`ifdef RBM_SEQ_ARGMAX_EN
  typedef enum logic [2:0] {StIdle, StHidden, StClassi, StDone, StArgmax} rbm_state_e;
`else
  typedef enum logic [1:0] {StIdle, StHidden, StClassi, StDone} rbm_state_e;
`endif

endpackage

// File: rtl/rbm_spike_counter_bank.sv
// Per-class saturating spike counters with a combinational read port.
// RBM_SEQ_ARGMAX_EN adds a one-class-per-cycle argmax over the counters.
module rbm_spike_counter_bank import rbm_pkg::*; #(
  parameter int unsigned N_CLASS = N_CLASS_DEF,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc_en,
  input  logic [CLS_W-1:0] inc_sel,
  input  logic             inc_val,
  input  logic [3:0]       count_sel,
  output logic [CNT_W-1:0] count_out
`ifdef RBM_SEQ_ARGMAX_EN
  ,
  input  logic             argmax_step,
  input  logic [CLS_W-1:0] argmax_sel,
  input  logic             winner_set,
  output logic [3:0]       winner,
  output logic             winner_valid
`endif
);

  logic [CNT_W-1:0] cnt_q [N_CLASS];

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_CLASS; i++) begin
      if (reset || clear) begin
        cnt_q[i] <= '0;
      end else if (inc_en && inc_val && inc_sel == CLS_W'(i) && !(&cnt_q[i])) begin
        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    count_out = '0;
    for (int i = 0; i < N_CLASS; i++) begin
      if (count_sel == 4'(i)) count_out = cnt_q[i];
    end
  end

`ifdef RBM_SEQ_ARGMAX_EN
  logic [CNT_W-1:0] arg_cnt;
  logic [CNT_W-1:0] best_q;
  logic [CLS_W-1:0] best_idx_q;
  logic             valid_q;

  always_comb begin
    arg_cnt = '0;
    for (int i = 0; i < N_CLASS; i++) begin
      if (argmax_sel == CLS_W'(i)) arg_cnt = cnt_q[i];
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      best_q     <= '0;
      best_idx_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      if (argmax_step && (argmax_sel == '0 || arg_cnt > best_q)) begin
        best_q     <= arg_cnt;
        best_idx_q <= argmax_sel;
      end
      if (winner_set) valid_q <= 1'b1;
    end
  end

  assign winner       = best_idx_q;
  assign winner_valid = valid_q;
`endif

endmodule

// File: rtl/rbm_sequencer.sv
// Walks the RBM hidden and classifier datapaths for iter_num iterations, counting class spikes.
// RBM_SEQ_ARGMAX_EN adds winner/winner_valid and delays done by N_CLASS argmax cycles.
module rbm_sequencer import rbm_pkg::*; #(
  parameter int unsigned N_VISIBLE = N_VISIBLE_DEF,
  parameter int unsigned N_HIDDEN  = N_HIDDEN_DEF,
  parameter int unsigned N_CLASS   = N_CLASS_DEF,
  parameter int unsigned ITER_W    = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] iter_num,
  output logic              busy,
  output logic              done,
  output logic [PIX_W-1:0]  pixel_id,
  output logic [HID_W-1:0]  hidden_id,
  output logic [CLS_W-1:0]  spike_id,
  output logic              bias_sel,
  output logic              acc_clear,
  output logic              enable_hidden,
  output logic              enable_classi,
  output logic              hidden_pixel,
  input  logic              hidden,
  input  logic              spike,
  input  logic [3:0]        count_sel,
  output logic [CNT_W-1:0]  count_out
`ifdef RBM_SEQ_ARGMAX_EN
  ,
  output logic [3:0]        winner,
  output logic              winner_valid
`endif
);

  rbm_state_e          state_q, state_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [HID_W-1:0]    hid_q, hid_d;
  logic [CLS_W-1:0]    cls_q, cls_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [N_HIDDEN-1:0] hid_buf_q, hid_buf_d;
  logic                done_q, done_d;
  logic                cnt_clear, cnt_inc, buf_bit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pix_q     <= '0;
      hid_q     <= '0;
      cls_q     <= '0;
      iter_q    <= '0;
      hid_buf_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      hid_q     <= hid_d;
      cls_q     <= cls_d;
      iter_q    <= iter_d;
      hid_buf_q <= hid_buf_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    hid_d     = hid_q;
    cls_d     = cls_q;
    iter_d    = iter_q;
    hid_buf_d = hid_buf_q;
    done_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StHidden;
          pix_d     = '0;
          hid_d     = '0;
          cls_d     = '0;
          iter_d    = (iter_num == '0) ? ITER_W'(1) : iter_num;
          cnt_clear = 1'b1;
        end
      end
      StHidden: begin
        if (pix_q == PIX_W'(N_VISIBLE + 1)) begin
          for (int i = 0; i < N_HIDDEN; i++) begin
            if (hid_q == HID_W'(i)) hid_buf_d[i] = hidden;
          end
          pix_d = '0;
          if (hid_q == HID_W'(N_HIDDEN - 1)) begin
            state_d = StClassi;
            hid_d   = '0;
            cls_d   = '0;
          end else begin
            hid_d = hid_q + HID_W'(1);
          end
        end else begin
          pix_d = pix_q + PIX_W'(1);
        end
      end
      StClassi: begin
        if (hid_q == HID_W'(N_HIDDEN + 1)) begin
          cnt_inc = 1'b1;
          hid_d   = '0;
          if (cls_q == CLS_W'(N_CLASS - 1)) begin
            cls_d  = '0;
            iter_d = iter_q - ITER_W'(1);
            if (iter_q == ITER_W'(1)) begin
`ifdef RBM_SEQ_ARGMAX_EN
              state_d = StArgmax;
`else
              state_d = StDone;
              done_d  = 1'b1;
`endif
            end else begin
              state_d = StHidden;
            end
          end else begin
            cls_d = cls_q + CLS_W'(1);
          end
        end else begin
          hid_d = hid_q + HID_W'(1);
        end
      end
`ifdef RBM_SEQ_ARGMAX_EN
      StArgmax: begin
        if (cls_q == CLS_W'(N_CLASS - 1)) begin
          state_d = StDone;
          done_d  = 1'b1;
          cls_d   = '0;
        end else begin
          cls_d = cls_q + CLS_W'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    buf_bit = 1'b0;
    for (int i = 0; i < N_HIDDEN; i++) begin
      if (hid_q == HID_W'(i)) buf_bit = hid_buf_q[i];
    end
  end

  always_comb begin
    busy          = 1'b0;
    enable_hidden = 1'b0;
    enable_classi = 1'b0;
    pixel_id      = '0;
    hidden_id     = '0;
    spike_id      = '0;
    bias_sel      = 1'b0;
    acc_clear     = 1'b0;
    hidden_pixel  = 1'b0;
    unique case (state_q)
      StHidden: begin
        busy          = 1'b1;
        enable_hidden = 1'b1;
        pixel_id      = pix_q;
        hidden_id     = hid_q;
        bias_sel      = (pix_q == PIX_W'(N_VISIBLE));
        acc_clear     = (pix_q == '0);
      end
      StClassi: begin
        busy          = 1'b1;
        enable_classi = 1'b1;
        hidden_id     = hid_q;
        spike_id      = cls_q;
        bias_sel      = (hid_q == HID_W'(N_HIDDEN));
        acc_clear     = (hid_q == '0);
        hidden_pixel  = (hid_q == HID_W'(N_HIDDEN)) | buf_bit;
      end
`ifdef RBM_SEQ_ARGMAX_EN
      StArgmax: busy = 1'b1;
`endif
      default: ;
    endcase
  end

  assign done = done_q;

  rbm_spike_counter_bank #(
    .N_CLASS (N_CLASS),
    .CNT_W   (CNT_W)
  ) u_bank (
    .clock        (clock),
    .reset        (reset),
    .clear        (cnt_clear),
    .inc_en       (cnt_inc),
    .inc_sel      (cls_q),
    .inc_val      (spike),
    .count_sel    (count_sel),
    .count_out    (count_out)
`ifdef RBM_SEQ_ARGMAX_EN
    ,
    .argmax_step  (state_q == StArgmax),
    .argmax_sel   (cls_q),
    .winner_set   (done_d),
    .winner       (winner),
    .winner_valid (winner_valid)
`endif
  );

  enables_exclusive: assert property (@(posedge clock) disable iff (reset)
      !(enable_hidden && enable_classi));

endmodule
